// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: next-PC select, SRAM fetch request, IF/ID register
// Define IF_ADEL_CHECK_EN to flag misaligned fetches on adelD instead of issuing them.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branch_takenD,
    input  logic [31:0] branch_targetD,
    input  logic        exc_redirect,
    input  logic [31:0] exc_pc,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic        is_in_delayslotD
`ifdef IF_ADEL_CHECK_EN
    ,
    output logic        adelD
`endif
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] next_pc;
    logic        ifid_flush;
    logic        ifid_load;
    logic        delayslot;
    logic        fetch_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // BOOT issues the reset PC once and ignores every pipeline control input.
    always_comb begin
        state_d    = state_q;
        next_pc    = pcF;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        delayslot  = 1'b0;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                ifid_flush = 1'b1;
            end
            RUN: begin
                if (exc_redirect) begin
                    next_pc = exc_pc;
                end else if (stallF) begin
                    next_pc = pcF;
                end else if (branch_takenD) begin
                    next_pc = branch_targetD;
                end else begin
                    next_pc = pcF + 32'd4;
                end
                if (exc_redirect || flushD) begin
                    ifid_flush = 1'b1;
                end else if (!stallD) begin
                    ifid_load = 1'b1;
                end
                // A branch dropped by stallF does not tag the instruction; decode re-issues it.
                delayslot = branch_takenD && !stallF;
            end
        endcase
    end

`ifdef IF_ADEL_CHECK_EN
    logic pcF_bad;
    assign fetch_bad = (next_pc[1:0] != 2'b00);
    assign pcF_bad   = (pcF[1:0] != 2'b00);
`else
    assign fetch_bad = 1'b0;
`endif

    assign inst_sram_en   = !rst && !fetch_bad;
    assign inst_sram_wen  = 4'b0000;
    assign inst_sram_addr = next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcF              <= RESET_PC;
            pcD              <= 32'd0;
            instrD           <= 32'd0;
            validD           <= 1'b0;
            is_in_delayslotD <= 1'b0;
`ifdef IF_ADEL_CHECK_EN
            adelD            <= 1'b0;
`endif
        end else begin
            pcF <= next_pc;
            if (ifid_flush) begin
                instrD           <= 32'd0;
                validD           <= 1'b0;
                is_in_delayslotD <= 1'b0;
`ifdef IF_ADEL_CHECK_EN
                adelD            <= 1'b0;
`endif
            end else if (ifid_load) begin
                pcD              <= pcF;
                validD           <= 1'b1;
                is_in_delayslotD <= delayslot;
`ifdef IF_ADEL_CHECK_EN
                // The suppressed fetch returns no data, so the slot carries a zero instruction.
                instrD           <= pcF_bad ? 32'd0 : inst_sram_rdata;
                adelD            <= pcF_bad;
`else
                instrD           <= inst_sram_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: vector table, corner sequences, random vs model
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst, stallF, stallD, flushD, branch_takenD, exc_redirect;
    logic [31:0] branch_targetD, exc_pc;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_rdata;
    logic [31:0] pcF, instrD, pcD;
    logic        validD, is_in_delayslotD;
    logic        adelD;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .branch_takenD(branch_takenD), .branch_targetD(branch_targetD),
        .exc_redirect(exc_redirect), .exc_pc(exc_pc),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
        .pcF(pcF), .instrD(instrD), .pcD(pcD), .validD(validD),
        .is_in_delayslotD(is_in_delayslotD)
`ifdef IF_ADEL_CHECK_EN
        , .adelD(adelD)
`endif
    );

    typedef struct {
        logic        rst, sf, sd, fl, br;
        logic [31:0] tgt;
        logic        ex;
        logic [31:0] epc;
        logic [31:0] e_addr;
        logic        e_en;
        logic [31:0] e_pcF, e_pcD;
        logic        e_v, e_ds;
        logic [31:0] e_src;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C30F1E;
    endfunction

    function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fl,
                                input logic br, input logic [31:0] tgt, input logic ex,
                                input logic [31:0] epc, input logic [31:0] e_addr, input logic e_en,
                                input logic [31:0] e_pcF, input logic [31:0] e_pcD,
                                input logic e_v, input logic e_ds, input logic [31:0] e_src);
        vec_t v;
        v.rst = r; v.sf = sf; v.sd = sd; v.fl = fl; v.br = br; v.tgt = tgt;
        v.ex = ex; v.epc = epc; v.e_addr = e_addr; v.e_en = e_en;
        v.e_pcF = e_pcF; v.e_pcD = e_pcD; v.e_v = e_v; v.e_ds = e_ds; v.e_src = e_src;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sf, input logic sd, input logic fl,
                         input logic br, input logic [31:0] tgt, input logic ex, input logic [31:0] epc);
        rst = r; stallF = sf; stallD = sd; flushD = fl;
        branch_takenD = br; branch_targetD = tgt; exc_redirect = ex; exc_pc = epc;
    endtask

    // SRAM model: returns the word for the address presented in the previous cycle.
    task automatic tick();
        logic [31:0] cap;
        cap = inst_sram_addr;
        @(posedge clk);
        #1;
        inst_sram_rdata = mem_f(cap);
    endtask

    logic        m_boot, m_v, m_ds;
    logic [31:0] m_pc, m_pcD, m_instr, e_addr;
    logic        r, sf, sd, fl, br, ex;
    logic [31:0] tgt, epc;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        inst_sram_rdata = 32'd0;

        vecs[0]  = mk(1,0,0,0,0,32'h0,0,32'h0,         32'h0,         0, RST_PC,        32'h0,         0,0,32'h0);
        vecs[1]  = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC00000,  1, 32'hBFC00000,  32'h0,         0,0,32'h0);
        vecs[2]  = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC00004,  1, 32'hBFC00004,  32'hBFC00000,  1,0,32'hBFC00000);
        vecs[3]  = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC00008,  1, 32'hBFC00008,  32'hBFC00004,  1,0,32'hBFC00004);
        vecs[4]  = mk(0,0,0,0,1,32'h80001000,0,32'h0,  32'h80001000,  1, 32'h80001000,  32'hBFC00008,  1,1,32'hBFC00008);
        vecs[5]  = mk(0,0,0,0,0,32'h0,0,32'h0,         32'h80001004,  1, 32'h80001004,  32'h80001000,  1,0,32'h80001000);
        vecs[6]  = mk(0,0,0,0,1,32'hBFC00010,0,32'h0,  32'hBFC00010,  1, 32'hBFC00010,  32'h80001004,  1,1,32'h80001004);
        vecs[7]  = mk(0,1,1,0,0,32'h0,0,32'h0,         32'hBFC00010,  1, 32'hBFC00010,  32'h80001004,  1,1,32'h80001004);
        vecs[8]  = mk(0,1,1,0,0,32'h0,0,32'h0,         32'hBFC00010,  1, 32'hBFC00010,  32'h80001004,  1,1,32'h80001004);
        vecs[9]  = mk(0,1,1,0,0,32'h0,0,32'h0,         32'hBFC00010,  1, 32'hBFC00010,  32'h80001004,  1,1,32'h80001004);
        vecs[10] = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC00014,  1, 32'hBFC00014,  32'hBFC00010,  1,0,32'hBFC00010);
        vecs[11] = mk(0,1,0,0,1,32'h80002000,1,32'hBFC00380, 32'hBFC00380, 1, 32'hBFC00380, 32'h0, 0,0,32'h0);
        vecs[12] = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC00384,  1, 32'hBFC00384,  32'hBFC00380,  1,0,32'hBFC00380);
        vecs[13] = mk(0,0,1,1,0,32'h0,0,32'h0,         32'hBFC00388,  1, 32'hBFC00388,  32'h0,         0,0,32'h0);
        vecs[14] = mk(0,1,1,0,1,32'h80003000,0,32'h0,  32'hBFC00388,  1, 32'hBFC00388,  32'h0,         0,0,32'h0);
        vecs[15] = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC0038C,  1, 32'hBFC0038C,  32'hBFC00388,  1,0,32'hBFC00388);
        vecs[16] = mk(1,1,0,0,1,32'h80004000,0,32'h0,  32'h0,         0, RST_PC,        32'h0,         0,0,32'h0);
        vecs[17] = mk(0,1,0,1,1,32'h80004000,1,32'h80005000, 32'hBFC00000, 1, 32'hBFC00000, 32'h0, 0,0,32'h0);
        vecs[18] = mk(0,0,0,0,0,32'h0,0,32'h0,         32'hBFC00004,  1, 32'hBFC00004,  32'hBFC00000,  1,0,32'hBFC00000);

        @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].br,
                  vecs[i].tgt, vecs[i].ex, vecs[i].epc);
            #1;
            chk($sformatf("v%0d.en", i), {31'd0, inst_sram_en}, {31'd0, vecs[i].e_en});
            chk($sformatf("v%0d.wen", i), {28'd0, inst_sram_wen}, 32'd0);
            if (!vecs[i].rst) chk($sformatf("v%0d.addr", i), inst_sram_addr, vecs[i].e_addr);
            tick();
            chk($sformatf("v%0d.pcF", i), pcF, vecs[i].e_pcF);
            chk($sformatf("v%0d.validD", i), {31'd0, validD}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d.dslot", i), {31'd0, is_in_delayslotD}, {31'd0, vecs[i].e_ds});
            chk($sformatf("v%0d.instrD", i), instrD, vecs[i].e_v ? mem_f(vecs[i].e_src) : 32'd0);
            if (vecs[i].e_v || vecs[i].rst) chk($sformatf("v%0d.pcD", i), pcD, vecs[i].e_pcD);
        end

`ifdef IF_ADEL_CHECK_EN
        drive(0, 0, 0, 0, 1, 32'h80001002, 0, 0);
        #1;
        chk("adel.en_off", {31'd0, inst_sram_en}, 32'd0);
        chk("adel.addr", inst_sram_addr, 32'h80001002);
        tick();
        chk("adel.pcF", pcF, 32'h80001002);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        tick();
        chk("adel.adelD", {31'd0, adelD}, 32'd1);
        chk("adel.pcD", pcD, 32'h80001002);
        chk("adel.validD", {31'd0, validD}, 32'd1);
        chk("adel.instrD", instrD, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBFC00100);
        #1;
        chk("adel.en_back", {31'd0, inst_sram_en}, 32'd1);
        tick();
        chk("adel.cleared", {31'd0, adelD}, 32'd0);
`else
        drive(0, 0, 0, 0, 1, 32'h80001002, 0, 0);
        #1;
        chk("noadel.en", {31'd0, inst_sram_en}, 32'd1);
        chk("noadel.addr", inst_sram_addr, 32'h80001002);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        tick();
        chk("noadel.pcD", pcD, 32'h80001002);
        chk("noadel.instrD", instrD, mem_f(32'h80001002));
`endif

        drive(1, 1, 1, 0, 1, 32'h80006000, 1, 32'h12345678);
        #1;
        chk("rstred.en", {31'd0, inst_sram_en}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rstred.addr", inst_sram_addr, RST_PC);
        tick();
        chk("rstred.pcF", pcF, RST_PC);
        chk("rstred.validD", {31'd0, validD}, 32'd0);

        m_boot = 1; m_pc = RST_PC; m_pcD = 0; m_instr = 0; m_v = 0; m_ds = 0;
        for (int i = 0; i < 600; i++) begin
            r   = (i == 0) || ($urandom_range(0, 59) == 0);
            sf  = ($urandom_range(0, 4) == 0);
            sd  = sf || ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 3) == 0);
            ex  = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'hFFFFFFFC;
            epc = $urandom & 32'hFFFFFFFC;
            if (m_boot)    e_addr = m_pc;
            else if (ex)   e_addr = epc;
            else if (sf)   e_addr = m_pc;
            else if (br)   e_addr = tgt;
            else           e_addr = m_pc + 32'd4;
            drive(r, sf, sd, fl, br, tgt, ex, epc);
            #1;
            chk($sformatf("r%0d.en", i), {31'd0, inst_sram_en}, {31'd0, !r});
            if (!r) chk($sformatf("r%0d.addr", i), inst_sram_addr, e_addr);
            tick();
            if (r) begin
                m_boot = 1; m_pc = RST_PC; m_pcD = 0; m_instr = 0; m_v = 0; m_ds = 0;
            end else begin
                if (m_boot || ex || fl) begin
                    m_instr = 0; m_v = 0; m_ds = 0;
                end else if (!sd) begin
                    m_instr = mem_f(m_pc); m_pcD = m_pc; m_v = 1; m_ds = br && !sf;
                end
                m_pc = e_addr;
                m_boot = 0;
            end
            chk($sformatf("r%0d.pcF", i), pcF, m_pc);
            chk($sformatf("r%0d.validD", i), {31'd0, validD}, {31'd0, m_v});
            chk($sformatf("r%0d.instrD", i), instrD, m_instr);
            chk($sformatf("r%0d.dslot", i), {31'd0, is_in_delayslotD}, {31'd0, m_ds});
            if (m_v || r) chk($sformatf("r%0d.pcD", i), pcD, m_pcD);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
